// File: rtl/bias_add_pkg.sv
// Shared types and default sizing for the bias-add frame arbiter slice.
package bias_add_pkg;
  localparam int TILE_SIZE   = 4;
  localparam int DATA_WIDTH  = 16;
  localparam int FRAME_BEATS = 64;
  localparam int VEC_W       = TILE_SIZE * DATA_WIDTH;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {IDLE, SOF, STREAM, DRAIN} arb_state_e;
endpackage

// File: rtl/bias_add_frame_arb_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last goes next.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       any
);
  assign any     = |req;
  assign gnt_idx = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/bias_add_frame_arb.sv
// Shares one bias-add datapath between two requesters a whole frame at a time.
// Optional perf counters (frames0/frames1/stall_cycles) are built when BIAS_ARB_PERF_EN is defined.
module bias_add_frame_arb #(
  parameter int TILE_SIZE   = bias_add_pkg::TILE_SIZE,
  parameter int DATA_WIDTH  = bias_add_pkg::DATA_WIDTH,
  parameter int FRAME_BEATS = bias_add_pkg::FRAME_BEATS,
  parameter int MAX_OUT     = 1,
  parameter int VEC_W       = TILE_SIZE * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [VEC_W-1:0] req0_vec,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [VEC_W-1:0] req1_vec,
  output logic             dp_in_valid,
  input  logic             dp_in_ready,
  output logic [VEC_W-1:0] dp_in_vec,
  output logic             dp_sof,
  input  logic             dp_out_valid,
  output logic             dp_out_ready,
  input  logic [VEC_W-1:0] dp_out_vec,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [VEC_W-1:0] rsp0_vec,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [VEC_W-1:0] rsp1_vec,
  output logic             owner,
  output logic             busy
`ifdef BIAS_ARB_PERF_EN
  ,
  output logic [15:0]      frames0,
  output logic [15:0]      frames1,
  output logic [15:0]      stall_cycles
`endif
);
  import bias_add_pkg::*;

  localparam int CNT_W = $clog2(FRAME_BEATS);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  arb_state_e       state;
  logic             owner_r;
  logic             last_owner;
  logic [CNT_W-1:0] beat_cnt;
  logic [OUT_W-1:0] outstanding;
  logic             gnt_idx;
  logic             any_req;
  logic             streaming;
  logic             routing;
  logic             room;
  logic             own_valid;
  logic [VEC_W-1:0] own_vec;
  logic             in_fire;
  logic             out_fire;

  rr_arb2 u_rr_arb2 (
    .req     ({req1_valid, req0_valid}),
    .last    (last_owner),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  assign streaming = (state == STREAM);
  assign routing   = (state == STREAM) || (state == DRAIN);
  assign room      = (outstanding < OUT_W'(MAX_OUT));
  assign own_valid = owner_r ? req1_valid : req0_valid;
  assign own_vec   = owner_r ? req1_vec : req0_vec;

  // Request side: owner's stream passes straight through, throttled by the in-flight limit.
  assign dp_in_valid = streaming && own_valid && room;
  assign dp_in_vec   = streaming ? own_vec : '0;
  assign req0_ready  = streaming && !owner_r && dp_in_ready && room;
  assign req1_ready  = streaming && owner_r && dp_in_ready && room;
  assign in_fire     = dp_in_valid && dp_in_ready;

  // Response side: results go back only to the frame owner.
  assign dp_out_ready = routing && (owner_r ? rsp1_ready : rsp0_ready);
  assign rsp0_valid   = routing && !owner_r && dp_out_valid;
  assign rsp1_valid   = routing && owner_r && dp_out_valid;
  assign rsp0_vec     = (routing && !owner_r) ? dp_out_vec : '0;
  assign rsp1_vec     = (routing && owner_r) ? dp_out_vec : '0;
  assign out_fire     = dp_out_valid && dp_out_ready;

  assign dp_sof = (state == SOF);
  assign busy   = (state != IDLE);
  assign owner  = owner_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_r    <= 1'b0;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_r <= gnt_idx;
            state   <= SOF;
          end
        end
        SOF: begin
          beat_cnt <= '0;
          state    <= STREAM;
        end
        STREAM: begin
          if (in_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_W'(FRAME_BEATS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            last_owner <= owner_r;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A same-cycle accept and return leave the in-flight count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (in_fire && !out_fire) begin
      outstanding <= outstanding + 1'b1;
    end else if (out_fire && !in_fire) begin
      outstanding <= outstanding - 1'b1;
    end
  end

`ifdef BIAS_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames0      <= '0;
      frames1      <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == DRAIN && outstanding == '0) begin
        if (owner_r) frames1 <= frames1 + 16'd1;
        else         frames0 <= frames0 + 16'd1;
      end
      if (streaming && own_valid && !in_fire && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif
endmodule

// File: doc/bias_add_frame_arb.md
Name: bias_add_frame_arb

Overview:
- Arbiter/sequencer that shares one bias-add datapath between two requester streams, granting it one whole frame (FRAME_BEATS tile beats) at a time.
- Issues the datapath's start-of-frame pulse one cycle before each frame's first beat, so the bias pointer always starts at tile 0.
- Limits in-flight beats to MAX_OUT, which enforces the datapath's "no new input before previous output accepted" requirement.
- Routes datapath results back to the requester that owns the current frame.

Parameters:
- TILE_SIZE, 4, lanes per beat.
- DATA_WIDTH, 16, bits per lane.
- FRAME_BEATS, 64, beats per frame; one bias-ROM sweep.
- MAX_OUT, 1, maximum beats accepted by the datapath but not yet returned.
- VEC_W, TILE_SIZE*DATA_WIDTH, packed beat width; lane0 in the LSBs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid / req0_ready / req0_vec  in/out/in  1/1/VEC_W  requester 0 input stream.
- req1_valid / req1_ready / req1_vec  in/out/in  1/1/VEC_W  requester 1 input stream.
- dp_in_valid / dp_in_ready / dp_in_vec  out/in/out  1/1/VEC_W  to datapath input.
- dp_sof  out  1  start-of-frame pulse to datapath.
- dp_out_valid / dp_out_ready / dp_out_vec  in/out/in  1/1/VEC_W  from datapath output.
- rsp0_valid / rsp0_ready / rsp0_vec  out/in/out  1/1/VEC_W  results to requester 0.
- rsp1_valid / rsp1_ready / rsp1_vec  out/in/out  1/1/VEC_W  results to requester 1.
- owner  out  1  requester currently granted; valid only while busy=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state=IDLE, owner=0, last_owner=1 (so requester 0 wins first), beat_cnt=0, outstanding=0.
  - All valid/ready/sof outputs 0; data outputs 0.
- States: IDLE -> SOF -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - If any reqK_valid is high, pick owner round-robin: on a tie, grant !last_owner; otherwise the single requester that is valid.
  - Go to SOF. No beat is accepted in IDLE.
- SOF:
  - dp_sof=1 for exactly this one cycle; dp_in_valid=0.
  - beat_cnt<=0; next state STREAM.
- STREAM:
  - dp_in_valid = req[owner]_valid && (outstanding < MAX_OUT).
  - req[owner]_ready = dp_in_ready && (outstanding < MAX_OUT).
  - dp_in_vec = req[owner]_vec; the non-owner's ready is 0.
  - On each dp accept, beat_cnt increments. When the accept has beat_cnt==FRAME_BEATS-1, go to DRAIN.
- DRAIN:
  - dp_in_valid=0.
  - Once outstanding==0, go to IDLE and set last_owner<=owner.
- Outstanding counter:
  - +1 on dp_in accept, -1 on dp_out fire, unchanged if both happen in the same cycle.
  - Never exceeds MAX_OUT and never goes below 0. A dp_out fire while outstanding==0 is a protocol error (bench assertion).
- Response routing (STREAM/DRAIN only):
  - rsp[owner]_valid = dp_out_valid; rsp[owner]_vec = dp_out_vec.
  - dp_out_ready = rsp[owner]_ready.
  - The other requester's rsp valid is 0. In IDLE/SOF, dp_out_ready=0.
- Combinational paths:
  - req->dp and dp->rsp are combinational pass-through; no extra latency is added.
  - End-to-end latency per beat = datapath latency (3 cycles in to out at MAX_OUT=1).
- Frame boundaries:
  - Frame turnaround is at least 2 idle dp cycles (IDLE, SOF) after the last result drains.
  - The grant is held for the whole frame even if the owner's valid drops mid-frame; the arbiter waits, never pre-empts.
- Reset mid-frame: all state clears asynchronously; the datapath shares rst_n, so no stale in-flight beats survive.

Optional Feature:
- Macro: BIAS_ARB_PERF_EN.
- When defined, adds these outputs:
  - frames0, frames1 (16 bits): increment on DRAIN->IDLE for that owner, wrap at 0xFFFF.
  - stall_cycles (16 bits, saturating): counts STREAM cycles where req[owner]_valid=1 but no accept occurred.
  - All three reset to 0.
- When undefined, these ports and their logic are absent.

Decomposition:
- Package bias_add_pkg holds:
  - TILE_SIZE, DATA_WIDTH, FRAME_BEATS.
  - vec_t typedef (packed VEC_W).
  - arb_state_e enum {IDLE, SOF, STREAM, DRAIN}.
- One sub-module, rr_arb2: a 2-way round-robin picker with inputs req[1:0] and last, and outputs gnt_idx and any.

Test Plan:
- Single frame: only req0 sends 64 beats with vec=beat index, dp_out_ready=1:
  - dp_sof pulses once, one cycle before the first dp_in accept.
  - 64 rsp0 beats return in order; rsp1_valid is never 1.
  - busy falls after the 64th result.
- Contention: req0 and req1 both valid from reset:
  - Frames granted in order 0,1,0,1.
  - No beat interleaving within a frame; owner changes only while in IDLE.
- Backpressure: rsp0_ready held 0 for 10 cycles mid-frame:
  - outstanding stays at 1 and dp_in_valid=0.
  - req0_ready=0 throughout; no beats are lost or duplicated.
- Bubbles: req0_valid drops for 5 cycles at beat 30:
  - State remains STREAM and owner remains 0 even though req1 is valid.
  - Frame completes with 64 beats.
- Reset: assert rst_n=0 at beat 20 of a frame:
  - All outputs are 0 and state is IDLE immediately.
  - The next frame starts with a dp_sof pulse.
- BIAS_ARB_PERF_EN defined, three frames (0,1,0) with 4 forced stall cycles:
  - frames0=2, frames1=1, stall_cycles=4.
